tag_cmp_arb: RTL and testbench

- Parametrised successor to the dcache tag-compare/arbiter stage. Sits between NR_PORTS cache controllers and the per-way tag/data SRAM banks.
- Arbitrates requests, with fixed-priority or round-robin selectable at elaboration, and honours SRAM back-pressure.
- Compares the late-arriving tag against the tag of every requested way, one cycle after grant. Produces one-hot and encoded hit information.
- Provides a sticky multi-hit error and saturating hit/miss counters.

---
 rtl/tag_cmp_arb_if.sv | 57 +++++
 rtl/tag_cmp_arb.sv | 155 +++++++++++++++
 tb/tb_tag_cmp_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_cmp_arb_if.sv
// Port-side request bus and SRAM-side bus of the tag-compare/arbiter stage.
// The master side belongs to whoever drives the requests and SRAM read data.
interface tag_cmp_arb_if #(
    parameter int NR_PORTS   = 3,
    parameter int WAYS       = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128,
    parameter int TAG_WIDTH  = 44,
    parameter int CNT_WIDTH  = 16
);
    localparam int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [NR_PORTS-1:0][WAYS-1:0]       req_i;
    logic [NR_PORTS-1:0]                 gnt_o;
    logic [NR_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
    logic [NR_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [NR_PORTS-1:0]                 we_i;
    logic [NR_PORTS-1:0][BE_W-1:0]       be_i;
    logic [NR_PORTS-1:0][TAG_WIDTH-1:0]  tag_i;
    logic                                mem_ready_i;
    logic [WAYS-1:0]                     req_o;
    logic [ADDR_WIDTH-1:0]               addr_o;
    logic [DATA_WIDTH-1:0]               wdata_o;
    logic                                we_o;
    logic [BE_W-1:0]                     be_o;
    logic [WAYS-1:0][DATA_WIDTH-1:0]     rdata_i;
    logic [WAYS-1:0][TAG_WIDTH-1:0]      rtag_i;
    logic [WAYS-1:0]                     rvalid_i;
    logic [WAYS-1:0][DATA_WIDTH-1:0]     rdata_o;
    logic                                hit_valid_o;
    logic [NR_PORTS-1:0]                 hit_port_o;
    logic [WAYS-1:0]                     hit_way_o;
    logic [IDX_W-1:0]                    hit_idx_o;
    logic                                hit_o;
    logic                                multi_hit_o;
    logic                                err_o;
    logic                                clr_err_i;
    logic [CNT_WIDTH-1:0]                hit_cnt_o;
    logic [CNT_WIDTH-1:0]                miss_cnt_o;

    modport master (
        output req_i, addr_i, wdata_i, we_i, be_i, tag_i, mem_ready_i,
               rdata_i, rtag_i, rvalid_i, clr_err_i,
        input  gnt_o, req_o, addr_o, wdata_o, we_o, be_o, rdata_o,
               hit_valid_o, hit_port_o, hit_way_o, hit_idx_o, hit_o,
               multi_hit_o, err_o, hit_cnt_o, miss_cnt_o
    );

    modport slave (
        input  req_i, addr_i, wdata_i, we_i, be_i, tag_i, mem_ready_i,
               rdata_i, rtag_i, rvalid_i, clr_err_i,
        output gnt_o, req_o, addr_o, wdata_o, we_o, be_o, rdata_o,
               hit_valid_o, hit_port_o, hit_way_o, hit_idx_o, hit_o,
               multi_hit_o, err_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/tag_cmp_arb.sv
// Dcache tag-compare/arbiter stage: grants one of NR_PORTS requesters to the
// way SRAMs, then compares the late tag against every requested way next cycle.
module tag_cmp_arb #(
    parameter int NR_PORTS   = 3,
    parameter int WAYS       = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128,
    parameter int TAG_WIDTH  = 44,
    parameter int ARB_RR     = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    tag_cmp_arb_if.slave  bus
);
    localparam int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NR_PORTS-1:0]  id_q, id_d;
    logic [WAYS-1:0]      way_q, way_d;
    logic                 cmp_valid_q, cmp_valid_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic [NR_PORTS-1:0]  port_req;
    logic [NR_PORTS-1:0]  gnt;
    logic                 win_vld;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     cand;
    logic [TAG_WIDTH-1:0] sel_tag;
    logic [WAYS-1:0]      hit_way;
    logic [IDX_W-1:0]     hit_idx;
    logic                 multi_hit;

    // The search origin is rr_ptr_q in round-robin mode and port 0 otherwise.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            port_req[p] = |bus.req_i[p];
        end
        for (int k = 0; k < NR_PORTS; k++) begin
            int c;
            c = (ARB_RR != 0) ? int'(rr_ptr_q) + k : k;
            if (c >= NR_PORTS) c = c - NR_PORTS;
            cand = PTR_W'(c);
            if (!win_vld && port_req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        if (!bus.mem_ready_i) win_vld = 1'b0;
        for (int p = 0; p < NR_PORTS; p++) begin
            gnt[p] = win_vld && (win_idx == PTR_W'(p));
        end
    end

    always_comb begin
        bus.req_o   = '0;
        bus.addr_o  = '0;
        bus.wdata_o = '0;
        bus.we_o    = 1'b0;
        bus.be_o    = '0;
        if (win_vld) begin
            bus.req_o   = bus.req_i[win_idx];
            bus.addr_o  = bus.addr_i[win_idx];
            bus.wdata_o = bus.wdata_i[win_idx];
            bus.we_o    = bus.we_i[win_idx];
            bus.be_o    = bus.be_i[win_idx];
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        way_d       = way_q;
        we_d        = we_q;
        cmp_valid_d = win_vld;
        if (win_vld) begin
            rr_ptr_d = (int'(win_idx) == NR_PORTS - 1) ? '0 : win_idx + 1'b1;
            id_d     = gnt;
            way_d    = bus.req_i[win_idx];
            we_d     = bus.we_i[win_idx];
        end
    end

    // Compare stage: the tag arrives from the port that won last cycle.
    always_comb begin
        sel_tag = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (id_q[p]) sel_tag = bus.tag_i[p];
        end
        for (int j = 0; j < WAYS; j++) begin
            hit_way[j] = cmp_valid_q & way_q[j] & bus.rvalid_i[j] &
                         (bus.rtag_i[j] == sel_tag);
        end
        hit_idx = '0;
        for (int j = WAYS - 1; j >= 0; j--) begin
            if (hit_way[j]) hit_idx = IDX_W'(j);
        end
        multi_hit = $countones(hit_way) > 1;

        err_d = err_q;
        if (bus.clr_err_i) err_d = 1'b0;
        if (multi_hit) err_d = 1'b1;

        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cmp_valid_q && !we_q) begin
            if (|hit_way) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            id_q        <= '0;
            way_q       <= '0;
            cmp_valid_q <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            way_q       <= way_d;
            cmp_valid_q <= cmp_valid_d;
            we_q        <= we_d;
            err_q       <= err_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.rdata_o     = bus.rdata_i;
    assign bus.hit_valid_o = cmp_valid_q;
    assign bus.hit_port_o  = id_q;
    assign bus.hit_way_o   = hit_way;
    assign bus.hit_idx_o   = hit_idx;
    assign bus.hit_o       = |hit_way;
    assign bus.multi_hit_o = multi_hit;
    assign bus.err_o       = err_q;
    assign bus.hit_cnt_o   = hit_cnt_q;
    assign bus.miss_cnt_o  = miss_cnt_q;
endmodule

// File: tb/tb_tag_cmp_arb.sv
// Bench for tag_cmp_arb: a fixed-priority and a round-robin instance share one
// stimulus stream; a reference model feeds per-instance scoreboards.
module tb_tag_cmp_arb;
    localparam int NP = 3;
    localparam int NW = 8;
    localparam int AW = 12;
    localparam int DW = 128;
    localparam int TW = 44;
    localparam int CW = 2;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    tag_cmp_arb_if #(.NR_PORTS(NP), .WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .TAG_WIDTH(TW), .CNT_WIDTH(CW)) b0 ();
    tag_cmp_arb_if #(.NR_PORTS(NP), .WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .TAG_WIDTH(TW), .CNT_WIDTH(CW)) b1 ();

    tag_cmp_arb #(.NR_PORTS(NP), .WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .TAG_WIDTH(TW), .ARB_RR(0), .CNT_WIDTH(CW))
        dut_fp (.clk_i(clk), .rst_ni(rst_ni), .bus(b0.slave));
    tag_cmp_arb #(.NR_PORTS(NP), .WAYS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .TAG_WIDTH(TW), .ARB_RR(1), .CNT_WIDTH(CW))
        dut_rr (.clk_i(clk), .rst_ni(rst_ni), .bus(b1.slave));

    // Shared stimulus
    logic [NP-1:0][NW-1:0] req;
    logic [NP-1:0][AW-1:0] addr;
    logic [NP-1:0][DW-1:0] wdata;
    logic [NP-1:0]         we;
    logic [NP-1:0][BW-1:0] be;
    logic [NP-1:0][TW-1:0] tag;
    logic                  mem_ready, clr;
    logic [NW-1:0][DW-1:0] rdata;
    logic [NW-1:0][TW-1:0] rtag;
    logic [NW-1:0]         rvalid;

    assign b0.req_i = req;     assign b1.req_i = req;
    assign b0.addr_i = addr;   assign b1.addr_i = addr;
    assign b0.wdata_i = wdata; assign b1.wdata_i = wdata;
    assign b0.we_i = we;       assign b1.we_i = we;
    assign b0.be_i = be;       assign b1.be_i = be;
    assign b0.tag_i = tag;     assign b1.tag_i = tag;
    assign b0.mem_ready_i = mem_ready; assign b1.mem_ready_i = mem_ready;
    assign b0.clr_err_i = clr; assign b1.clr_err_i = clr;
    assign b0.rdata_i = rdata; assign b1.rdata_i = rdata;
    assign b0.rtag_i = rtag;   assign b1.rtag_i = rtag;
    assign b0.rvalid_i = rvalid; assign b1.rvalid_i = rvalid;

    // Outputs of both instances, indexed by instance
    logic [NP-1:0]         o_gnt[2];
    logic [NW-1:0]         o_req[2];
    logic [AW-1:0]         o_addr[2];
    logic [DW-1:0]         o_wdata[2];
    logic                  o_we[2];
    logic [BW-1:0]         o_be[2];
    logic [NW-1:0][DW-1:0] o_rdata[2];
    logic                  o_hv[2];
    logic [NP-1:0]         o_hport[2];
    logic [NW-1:0]         o_hway[2];
    logic [2:0]            o_hidx[2];
    logic                  o_hit[2], o_multi[2], o_err[2];
    logic [CW-1:0]         o_hc[2], o_mc[2];

    assign o_gnt[0] = b0.gnt_o;         assign o_gnt[1] = b1.gnt_o;
    assign o_req[0] = b0.req_o;         assign o_req[1] = b1.req_o;
    assign o_addr[0] = b0.addr_o;       assign o_addr[1] = b1.addr_o;
    assign o_wdata[0] = b0.wdata_o;     assign o_wdata[1] = b1.wdata_o;
    assign o_we[0] = b0.we_o;           assign o_we[1] = b1.we_o;
    assign o_be[0] = b0.be_o;           assign o_be[1] = b1.be_o;
    assign o_rdata[0] = b0.rdata_o;     assign o_rdata[1] = b1.rdata_o;
    assign o_hv[0] = b0.hit_valid_o;    assign o_hv[1] = b1.hit_valid_o;
    assign o_hport[0] = b0.hit_port_o;  assign o_hport[1] = b1.hit_port_o;
    assign o_hway[0] = b0.hit_way_o;    assign o_hway[1] = b1.hit_way_o;
    assign o_hidx[0] = b0.hit_idx_o;    assign o_hidx[1] = b1.hit_idx_o;
    assign o_hit[0] = b0.hit_o;         assign o_hit[1] = b1.hit_o;
    assign o_multi[0] = b0.multi_hit_o; assign o_multi[1] = b1.multi_hit_o;
    assign o_err[0] = b0.err_o;         assign o_err[1] = b1.err_o;
    assign o_hc[0] = b0.hit_cnt_o;      assign o_hc[1] = b1.hit_cnt_o;
    assign o_mc[0] = b0.miss_cnt_o;     assign o_mc[1] = b1.miss_cnt_o;

    // Reference model state (instance 0 fixed priority, instance 1 round-robin)
    typedef struct {
        bit            v;
        logic [1:0]    port;
        logic [NW-1:0] ways;
        bit            wr;
    } pend_t;
    typedef struct {
        logic [NP-1:0] port;
        logic [NW-1:0] way;
        logic [2:0]    idx;
        logic          hit;
        logic          multi;
    } exp_t;

    pend_t pend[2];
    int    ptr_m[2];
    int    hc_m[2];
    int    mc_m[2];
    bit    err_m[2];
    exp_t  sbq[2][$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
    endtask

    function automatic int pick(input int d);
        if (!mem_ready) return -1;
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (d == 1) ? (ptr_m[d] + k) % NP : k;
            if (|req[p]) return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pend[d].v = 0;
            ptr_m[d] = 0;
            hc_m[d] = 0;
            mc_m[d] = 0;
            err_m[d] = 0;
            sbq[d].delete();
        end
    endtask

    task automatic idle();
        req = '0; we = '0; mem_ready = 1'b1; clr = 1'b0; tag = '0; rvalid = '1;
        for (int p = 0; p < NP; p++) begin
            addr[p] = AW'(p * 16 + 1);
            wdata[p] = {4{32'(p + 1)}};
            be[p] = '1;
        end
        for (int j = 0; j < NW; j++) begin
            rtag[j] = TW'(100 + j);
            rdata[j] = {4{32'(j + 7)}};
        end
    endtask

    task automatic rand_in();
        mem_ready = ($urandom_range(3) != 0);
        clr = ($urandom_range(15) == 0);
        for (int p = 0; p < NP; p++) begin
            req[p] = ($urandom_range(2) == 0) ? '0 : NW'($urandom);
            addr[p] = AW'($urandom);
            wdata[p] = {$urandom, $urandom, $urandom, $urandom};
            we[p] = ($urandom_range(3) == 0);
            be[p] = BW'($urandom);
            tag[p] = TW'($urandom_range(3));
        end
        for (int j = 0; j < NW; j++) begin
            rtag[j] = TW'($urandom_range(5));
            rvalid[j] = ($urandom_range(3) != 0);
            rdata[j] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Called right after inputs change at the falling edge.
    task automatic eval();
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_t          e;
            int            g;
            int            cnt;
            logic [1:0]    gi;
            logic [NW-1:0] hw;
            logic [DW-1:0] wd;
            bit            multi;
            chk("err_o", d, 64'(o_err[d]), 64'(err_m[d]));
            chk("hit_cnt_o", d, 64'(o_hc[d]), 64'(hc_m[d]));
            chk("miss_cnt_o", d, 64'(o_mc[d]), 64'(mc_m[d]));
            multi = 0;
            if (pend[d].v) begin
                chk("sb_drained", d, 64'(sbq[d].size()), 64'(0));
                for (int j = 0; j < NW; j++)
                    hw[j] = pend[d].ways[j] && rvalid[j] && (rtag[j] == tag[pend[d].port]);
                cnt = $countones(hw);
                e.port = '0;
                e.port[pend[d].port] = 1'b1;
                e.way = hw;
                e.hit = (cnt > 0);
                e.multi = (cnt > 1);
                e.idx = 3'd0;
                for (int j = 0; j < NW; j++) begin
                    if (hw[j]) begin
                        e.idx = 3'(j);
                        break;
                    end
                end
                sbq[d].push_back(e);
                multi = e.multi;
                if (!pend[d].wr) begin
                    if (e.hit) begin
                        if (hc_m[d] < (1 << CW) - 1) hc_m[d]++;
                    end else begin
                        if (mc_m[d] < (1 << CW) - 1) mc_m[d]++;
                    end
                end
            end
            err_m[d] = multi ? 1'b1 : (clr ? 1'b0 : err_m[d]);

            g = pick(d);
            gi = (g < 0) ? 2'd0 : 2'(g);
            wd = (g < 0) ? '0 : wdata[gi];
            chk("gnt_o", d, 64'(o_gnt[d]), (g < 0) ? 64'(0) : 64'(1) << g);
            chk("req_o", d, 64'(o_req[d]), (g < 0) ? 64'(0) : 64'(req[gi]));
            chk("addr_o", d, 64'(o_addr[d]), (g < 0) ? 64'(0) : 64'(addr[gi]));
            chk("we_be_o", d, 64'({o_we[d], o_be[d]}),
                (g < 0) ? 64'(0) : 64'({we[gi], be[gi]}));
            chk("wdata_o_eq", d, 64'(o_wdata[d] == wd), 64'(1));
            chk("rdata_o_eq", d, 64'(o_rdata[d] == rdata), 64'(1));
            pend[d].v = (g >= 0);
            if (g >= 0) begin
                pend[d].port = gi;
                pend[d].ways = req[gi];
                pend[d].wr = we[gi];
                ptr_m[d] = (g + 1) % NP;
            end
        end
    endtask

    // Monitor: pops an expectation whenever an instance presents a result.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_ni) begin
                for (int d = 0; d < 2; d++) begin
                    exp_t e;
                    if (o_hv[d]) begin
                        if (sbq[d].size() == 0) begin
                            n_chk++;
                            $display("FAIL hit_valid_o dut%0d: got 1 expected 0", d);
                        end else begin
                            e = sbq[d].pop_front();
                            chk("hit_port_o", d, 64'(o_hport[d]), 64'(e.port));
                            chk("hit_way_o", d, 64'(o_hway[d]), 64'(e.way));
                            chk("hit_idx_o", d, 64'(o_hidx[d]), 64'(e.idx));
                            chk("hit_o", d, 64'(o_hit[d]), 64'(e.hit));
                            chk("multi_hit_o", d, 64'(o_multi[d]), 64'(e.multi));
                        end
                    end
                end
            end
        end
    end

    logic [2:0] rr_seq[4];

    initial begin
        rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;
        idle();
        model_reset();
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_hit_valid", d, 64'(o_hv[d]), 64'(0));
            chk("rst_hit_way", d, 64'(o_hway[d]), 64'(0));
            chk("rst_hit", d, 64'(o_hit[d]), 64'(0));
            chk("rst_multi", d, 64'(o_multi[d]), 64'(0));
            chk("rst_err", d, 64'(o_err[d]), 64'(0));
            chk("rst_hit_cnt", d, 64'(o_hc[d]), 64'(0));
            chk("rst_miss_cnt", d, 64'(o_mc[d]), 64'(0));
        end
        @(negedge clk);
        rst_ni = 1'b1;
        idle();
        eval();

        // All ports requesting continuously
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); req = '1; eval();
            chk("rr_sequence", 1, 64'(o_gnt[1]), 64'(rr_seq[i]));
            chk("fp_sequence", 0, 64'(o_gnt[0]), 64'(3'b001));
        end

        // Ports 0 and 2 request; next cycle way 5 holds the matching tag
        @(negedge clk); idle(); req[0] = '1; req[2] = 8'h0F; eval();
        chk("fp_gnt", 0, 64'(o_gnt[0]), 64'(3'b001));
        chk("fp_addr", 0, 64'(o_addr[0]), 64'(addr[0]));
        @(negedge clk); idle(); rtag[5] = TW'(44'h1234); tag = {NP{TW'(44'h1234)}}; eval();

        // Back-pressure, then a quiet cycle
        @(negedge clk); idle(); req = '1; mem_ready = 1'b0; eval();
        @(negedge clk); idle(); eval();

        // Only way 3 matches, but it is masked off in the request
        @(negedge clk); idle(); req[1] = 8'hF7; eval();
        @(negedge clk); idle(); rtag[3] = TW'(44'h55); tag = {NP{TW'(44'h55)}}; eval();

        // Ways 1 and 4 both match; error stays until cleared
        @(negedge clk); idle(); req[0] = '1; eval();
        @(negedge clk); idle(); rtag[1] = TW'(44'h77); rtag[4] = TW'(44'h77);
        tag = {NP{TW'(44'h77)}}; eval();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); eval();
        end
        @(negedge clk); idle(); clr = 1'b1; eval();
        @(negedge clk); idle(); eval();

        // Back-to-back hits drive the hit counter into saturation
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); idle(); req[0] = '1; req[1] = '1;
            rtag[0] = TW'(44'h9); tag = {NP{TW'(44'h9)}}; eval();
        end
        @(negedge clk); idle(); rtag[0] = TW'(44'h9); tag = {NP{TW'(44'h9)}}; eval();

        for (int i = 0; i < 400; i++) begin
            @(negedge clk); rand_in(); eval();
        end

        // Asynchronous reset while a compare is in flight
        @(negedge clk); idle(); req = '1; eval();
        @(posedge clk); #2;
        rst_ni = 1'b0;
        model_reset();
        @(negedge clk); #1;
        for (int d = 0; d < 2; d++) chk("hv_in_reset", d, 64'(o_hv[d]), 64'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        idle(); req = '1; eval();
        for (int d = 0; d < 2; d++) chk("hv_after_reset", d, 64'(o_hv[d]), 64'(0));

        for (int i = 0; i < 60; i++) begin
            @(negedge clk); rand_in(); eval();
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); eval();
        end
        #3;
        for (int d = 0; d < 2; d++) chk("sb_final_empty", d, 64'(sbq[d].size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
